sram_req_arbiter: RTL and testbench
===================================

# sram_req_arbiter

Two-to-one arbiter and sequencer that shares a single SRAM-like memory port between the instruction-fetch requester and the data-access requester of the LoongArch pipeline. It serves the IF-stage fetch path on one side and the EX/MEM load-store path on the other, and sits between the pipeline and the memory bridge. It keeps at most one outstanding transaction on the memory port. Each transaction is returned to the requester that owns it, with a one-cycle data_ok pulse and the registered read data.

## Interface
- MAX_DATA_STREAK, 4, consecutive data grants allowed while inst_req is pending before inst is forced to win (1..15)
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  one-cycle pulse, fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request, held until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte enables (stores)
- data_addr  in  32  access address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  one-cycle pulse, load data valid / store done
- data_rdata  out  32  load data (raw word; MEM stage extracts bytes/halves)
- mem_req  out  1  downstream request, held until mem_addr_ok
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  downstream request fields
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  32  downstream read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Owner register: 0 = inst, 1 = data.
- IDLE grant rule:
  - If data_req and not (inst_req and streak == MAX_DATA_STREAK), grant data.
  - Else if inst_req, grant inst.
  - Else stay in IDLE.
- On a grant:
  - Pulse the granted requester's addr_ok combinationally in the same cycle.
  - Latch the request fields. Inst requests latch wr = 0, size = 2, wstrb = 0, wdata = 0.
  - Set owner and go to ISSUE.
- addr_ok is asserted only in IDLE and only to the granted requester.
- Streak counter (4 bits):
  - Increments on each data grant made while inst_req = 1, saturating at MAX_DATA_STREAK.
  - Clears on any inst grant, and on any data grant made while inst_req = 0.
- ISSUE: mem_req = 1 and the mem_* fields carry the latched values.
  - On mem_addr_ok only, go to WAIT.
  - On mem_addr_ok and mem_data_ok in the same cycle, capture mem_rdata and go straight to RESP.
- WAIT: mem_req = 0. On mem_data_ok, capture mem_rdata into the rdata register and go to RESP.
- RESP: pulse the owner's data_ok for one cycle, then go to IDLE.
  - inst_rdata and data_rdata both show the captured register.
  - Only the owner's data_ok is asserted.
  - Stores also receive data_ok. The captured value is don't-care for stores.
- mem_data_ok in IDLE or RESP is ignored (no capture, no data_ok).
- The mem_* fields are registered and hold their last latched values outside ISSUE. Only mem_req qualifies them.

## Timing
- Reset (synchronous, dominates everything else):
  - State IDLE, owner 0, streak 0, rdata register 0.
  - All mem_* outputs 0. All addr_ok and data_ok outputs 0.
- Reset during ISSUE, WAIT or RESP abandons the transaction: no data_ok is emitted, and a later stray mem_data_ok is ignored.
- Best-case latency, grant at cycle T:
  - T+1: ISSUE, mem_req = 1. mem_addr_ok arrives at T+1.
  - T+2: WAIT. mem_data_ok arrives at T+2.
  - T+3: RESP, data_ok pulse.
  - T+4: IDLE, next grant possible.
- With addr_ok and data_ok in the same cycle at T+1: RESP at T+2, next grant at T+3.
- Throughput is at most one transaction per 3 cycles. There are no back-to-back grants.
- Requesters may change req, addr and fields freely after their addr_ok cycle.

## Test plan
- Single fetch: inst_req, addr 0x1C000000; mem_addr_ok at T+1, mem_data_ok at T+2 with rdata 0x02800C0C -> inst_addr_ok at T, inst_data_ok at T+3 with inst_rdata = 0x02800C0C, data_data_ok = 0.
- Simultaneous requests: inst_req and data_req both at T, data_wr = 1, addr 0x8000, wstrb 0x3, wdata 0x1234 -> data granted first, mem_wr = 1, mem_wstrb = 0x3, mem_size = 0 as driven. Inst is granted at the next IDLE and its data_ok follows data_data_ok.
- Starvation guard: MAX_DATA_STREAK = 4, data_req and inst_req held high continuously -> grant order D D D D I D D D D I ...
- Merged response: in ISSUE, mem_addr_ok = mem_data_ok = 1 with rdata 0xDEADBEEF -> data_ok next cycle with 0xDEADBEEF, WAIT skipped.
- Reset mid-WAIT: assert reset one cycle, then mem_data_ok = 1 -> no data_ok on either side, all outputs 0, next request granted normally.
- Stall downstream: mem_addr_ok held 0 for 10 cycles -> mem_req and fields stable, no second addr_ok issued, pending data_req not acknowledged.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like port between instruction fetch and data access.
// One outstanding transaction at a time; the response is routed back to the requester that owns it.
module sram_req_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic [STREAK_W-1:0] streak;
  logic [31:0]         rdata_q;
  logic                grant_inst;
  logic                grant_data;
  logic                capture;
  logic                streak_at_max;

  assign streak_at_max = (streak >= STREAK_W'(MAX_DATA_STREAK));

  // Next-state, grant and capture decode; reset suppresses every side effect.
  always_comb begin
    state_nxt  = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (data_req && !(inst_req && streak_at_max)) begin
          grant_data = 1'b1;
          state_nxt  = ISSUE;
        end else if (inst_req) begin
          grant_inst = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            capture   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      state_nxt  = IDLE;
      grant_inst = 1'b0;
      grant_data = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      streak    <= '0;
      rdata_q   <= '0;
      mem_wr    <= 1'b0;
      mem_size  <= '0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant_data) begin
        owner     <= 1'b1;
        mem_wr    <= data_wr;
        mem_size  <= data_size;
        mem_wstrb <= data_wstrb;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
        // Count data wins only while a fetch is being held off.
        if (inst_req) begin
          streak <= streak_at_max ? streak : streak + STREAK_W'(1);
        end else begin
          streak <= '0;
        end
      end
      if (grant_inst) begin
        owner     <= 1'b0;
        mem_wr    <= 1'b0;
        mem_size  <= 2'd2;
        mem_wstrb <= '0;
        mem_addr  <= inst_addr;
        mem_wdata <= '0;
        streak    <= '0;
      end
      if (capture) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign mem_req      = (state == ISSUE) && !reset;
  assign inst_data_ok = (state == RESP) && !owner && !reset;
  assign data_data_ok = (state == RESP) && owner && !reset;
  assign inst_rdata   = rdata_q;
  assign data_rdata   = rdata_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter with hand-computed expectations.
module tb_sram_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [1:0]  exp_g;

  sram_req_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = '0;
    data_wstrb  = '0;
    data_addr   = '0;
    data_wdata  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_inputs();
    reset = 1'b1;
    next();
    next();
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_size", 32'(mem_size), 32'd0);
    check("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rst_rdata", inst_rdata, 32'd0);
    inst_req = 1'b1;
    #1;
    check("rst_no_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    inst_req = 1'b0;

    // Single fetch, split handshake.
    next();
    reset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    #1;
    check("fetch_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd2);
    next();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    #1;
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h1C00_0000);
    check("fetch_mem_fields", 32'({mem_wr, mem_size, mem_wstrb}), 32'({1'b0, 2'd2, 4'h0}));
    next();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
    #1;
    check("fetch_wait_req", 32'(mem_req), 32'd0);
    next();
    mem_data_ok = 1'b0; mem_rdata = '0;
    #1;
    check("fetch_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd2);
    check("fetch_rdata", inst_rdata, 32'h0280_0C0C);
    next();
    #1;
    check("fetch_pulse_end", 32'(inst_data_ok), 32'd0);

    // Simultaneous requests: data store wins, fetch follows.
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_8000;
    data_wstrb = 4'h3; data_wdata = 32'h0000_1234;
    #1;
    check("sim_grant", 32'({inst_addr_ok, data_addr_ok}), 32'd1);
    next();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    #1;
    check("sim_mem_req", 32'(mem_req), 32'd1);
    check("sim_mem_fields", 32'({mem_wr, mem_size, mem_wstrb}), 32'({1'b1, 2'd0, 4'h3}));
    check("sim_mem_addr", mem_addr, 32'h0000_8000);
    check("sim_mem_wdata", mem_wdata, 32'h0000_1234);
    check("sim_no_inst_ok", 32'(inst_addr_ok), 32'd0);
    next();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    next();
    mem_data_ok = 1'b0;
    #1;
    check("sim_store_ok", 32'({inst_data_ok, data_data_ok}), 32'd1);
    next();
    #1;
    check("sim_inst_grant", 32'({inst_addr_ok, data_addr_ok}), 32'd2);
    next();
    inst_req = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("merge_mem_wr", 32'(mem_wr), 32'd0);
    next();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    check("merge_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd2);
    check("merge_rdata", inst_rdata, 32'hDEAD_BEEF);
    next();

    // Starvation guard: both held high, merged responses.
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
    data_addr = 32'h0000_0040; data_wstrb = 4'h0;
    for (int k = 0; k < 10; k++) begin
      exp_g = (k % 5 == 4) ? 2'b10 : 2'b01;
      #1;
      check("starve_grant", 32'({inst_addr_ok, data_addr_ok}), 32'(exp_g));
      next();
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
      next();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      #1;
      check("starve_data_ok", 32'({inst_data_ok, data_data_ok}), 32'(exp_g));
      check("starve_rdata", data_rdata, 32'hA000_0000 + 32'(k));
      next();
    end
    clr_inputs();

    // Reset while waiting for the response.
    data_req = 1'b1; data_addr = 32'h0000_0100; data_size = 2'd2;
    #1;
    check("rw_grant", 32'(data_addr_ok), 32'd1);
    next();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    next();
    mem_addr_ok = 1'b0; reset = 1'b1;
    next();
    reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0055;
    #1;
    check("rw_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rw_mem_cleared", 32'({mem_req, mem_wr, mem_size, mem_wstrb}), 32'd0);
    check("rw_mem_addr", mem_addr, 32'd0);
    check("rw_rdata", data_rdata, 32'd0);
    next();
    mem_data_ok = 1'b0;
    #1;
    check("rw_still_quiet", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rw_no_capture", data_rdata, 32'd0);
    data_req = 1'b1; data_addr = 32'h0000_0200;
    #1;
    check("rw_regrant", 32'(data_addr_ok), 32'd1);
    next();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    #1;
    check("rw_mem_addr2", mem_addr, 32'h0000_0200);
    next();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0077;
    next();
    mem_data_ok = 1'b0;
    #1;
    check("rw_resp", 32'({inst_data_ok, data_data_ok}), 32'd1);
    check("rw_resp_rdata", data_rdata, 32'h0000_0077);
    next();

    // Downstream stall: fields hold, no second acknowledge.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h0000_0300; data_wdata = 32'h0000_CAFE;
    #1;
    check("stall_grant", 32'(data_addr_ok), 32'd1);
    next();
    data_addr = 32'h0000_0400; data_wdata = 32'h0000_BEEF;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("stall_req", 32'({mem_req, data_addr_ok, inst_addr_ok}), 32'b100);
      check("stall_addr", mem_addr, 32'h0000_0300);
      check("stall_wdata", mem_wdata, 32'h0000_CAFE);
      next();
    end
    mem_addr_ok = 1'b1;
    next();
    mem_addr_ok = 1'b0;
    #1;
    check("stall_wait_hold", mem_addr, 32'h0000_0300);
    check("stall_wait_req", 32'({mem_req, data_addr_ok}), 32'd0);
    mem_data_ok = 1'b1;
    next();
    mem_data_ok = 1'b0;
    #1;
    check("stall_store_ok", 32'({inst_data_ok, data_data_ok}), 32'd1);
    next();
    #1;
    check("stall_pending_ack", 32'(data_addr_ok), 32'd1);
    next();
    clr_inputs();
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
